// File: rtl/ray_frame_scheduler.sv
// Frame scheduler: walks the raster, issues credit-gated pixel coordinates and
// holds a per-frame configuration snapshot. Optional SCHED_STALL_CNT_EN adds a stall-cycle counter.
module ray_frame_scheduler #(
  parameter int FP_W    = 32,
  parameter int PX_W    = 11,
  parameter int CREDITS = 16,
  parameter int CR_W    = 5
) (
  input  logic              clk,
  input  logic              rst_gen,
  input  logic              start,
  input  logic              abort,
  input  logic [PX_W-1:0]   width_px,
  input  logic [PX_W-1:0]   height_px,
  input  logic [FP_W-1:0]   x_start,
  input  logic [FP_W-1:0]   y_start,
  input  logic [FP_W-1:0]   x_step,
  input  logic [FP_W-1:0]   y_step,
  input  logic [3*FP_W-1:0] light_pos_in,
  input  logic [3*FP_W-1:0] cam_fwd_in,
  input  logic [3*FP_W-1:0] cam_right_in,
  input  logic [3*FP_W-1:0] ray_origin_in,
  input  logic              sdf_sel_in,
  output logic [FP_W-1:0]   screen_x,
  output logic [FP_W-1:0]   screen_y,
  output logic              pix_valid,
  output logic [3*FP_W-1:0] light_pos,
  output logic [3*FP_W-1:0] camera_forward,
  output logic [3*FP_W-1:0] camera_right,
  output logic [3*FP_W-1:0] ray_origin,
  output logic              sdf_sel,
  input  logic              pix_accept,
  output logic              busy,
  output logic              frame_done,
  output logic [CR_W-1:0]   credits
`ifdef SCHED_STALL_CNT_EN
  ,
  output logic [31:0]       stall_cycles
`endif
);

  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_DRAIN} state_t;

  localparam logic [CR_W-1:0] CR_FULL = CR_W'(CREDITS);
  localparam logic [CR_W-1:0] CR_ONE  = CR_W'(1);
  localparam logic [PX_W-1:0] PX_ONE  = PX_W'(1);

  // Credit update; an accept with the counter already full is dropped.
  function automatic logic [CR_W-1:0] credit_next(input logic [CR_W-1:0] c,
                                                  input logic iss, input logic acc);
    logic [CR_W-1:0] r;
    r = c;
    if (iss && !acc) begin
      r = c - CR_ONE;
    end else if (!iss && acc && (c != CR_FULL)) begin
      r = c + CR_ONE;
    end
    return r;
  endfunction

  state_t                   state_q, state_d;
  logic [CR_W-1:0]          cred_q, cred_d;
  logic [PX_W-1:0]          col_q, col_d, row_q, row_d;
  logic signed [FP_W-1:0]   cur_x_q, cur_x_d, cur_y_q, cur_y_d;
  logic [3*FP_W-1:0]        light_q, light_d, fwd_q, fwd_d;
  logic [3*FP_W-1:0]        right_q, right_d, orig_q, orig_d;
  logic                     sdf_q, sdf_d;
  logic                     done_q, done_d;

  // Frame geometry shadows; only consulted while a frame is active.
  logic [PX_W-1:0]          w_q, w_d, h_q, h_d;
  logic signed [FP_W-1:0]   xs_q, xs_d, xst_q, xst_d, yst_q, yst_d;

  logic issue;
  logic start_ok;
  logic last_col;
  logic last_row;

  assign issue    = (state_q == ST_ISSUE) && (cred_q != '0);
  assign start_ok = start && (width_px != '0) && (height_px != '0);
  assign last_col = (col_q == (w_q - PX_ONE));
  assign last_row = (row_q == (h_q - PX_ONE));

`ifdef SCHED_STALL_CNT_EN
  logic [31:0] stall_q, stall_d;

  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == '1) ? v : v + 32'd1;
  endfunction
`endif

  always_comb begin
    state_d = state_q;
    cred_d  = credit_next(cred_q, issue, pix_accept);
    col_d   = col_q;
    row_d   = row_q;
    cur_x_d = cur_x_q;
    cur_y_d = cur_y_q;
    light_d = light_q;
    fwd_d   = fwd_q;
    right_d = right_q;
    orig_d  = orig_q;
    sdf_d   = sdf_q;
    done_d  = 1'b0;
    w_d     = w_q;
    h_d     = h_q;
    xs_d    = xs_q;
    xst_d   = xst_q;
    yst_d   = yst_q;
`ifdef SCHED_STALL_CNT_EN
    stall_d = stall_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (start_ok) begin
          light_d = light_pos_in;
          fwd_d   = cam_fwd_in;
          right_d = cam_right_in;
          orig_d  = ray_origin_in;
          sdf_d   = sdf_sel_in;
          w_d     = width_px;
          h_d     = height_px;
          xs_d    = x_start;
          xst_d   = x_step;
          yst_d   = y_step;
          cur_x_d = x_start;
          cur_y_d = y_start;
          col_d   = '0;
          row_d   = '0;
          state_d = ST_ISSUE;
`ifdef SCHED_STALL_CNT_EN
          stall_d = '0;
`endif
        end else if (start) begin
          done_d = 1'b1;
        end
      end
      ST_ISSUE: begin
        if (issue) begin
          if (!last_col) begin
            col_d   = col_q + PX_ONE;
            cur_x_d = cur_x_q + xst_q;
          end else begin
            col_d   = '0;
            cur_x_d = xs_q;
            row_d   = row_q + PX_ONE;
            cur_y_d = cur_y_q + yst_q;
          end
          if (last_col && last_row) begin
            state_d = ST_DRAIN;
          end
        end
`ifdef SCHED_STALL_CNT_EN
        else begin
          stall_d = sat_inc32(stall_q);
        end
`endif
        if (abort) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (cred_q == CR_FULL) begin
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_gen) begin
    if (!rst_gen) begin
      state_q <= ST_IDLE;
      cred_q  <= CR_FULL;
      col_q   <= '0;
      row_q   <= '0;
      cur_x_q <= '0;
      cur_y_q <= '0;
      light_q <= '0;
      fwd_q   <= '0;
      right_q <= '0;
      orig_q  <= '0;
      sdf_q   <= 1'b0;
      done_q  <= 1'b0;
`ifdef SCHED_STALL_CNT_EN
      stall_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      cred_q  <= cred_d;
      col_q   <= col_d;
      row_q   <= row_d;
      cur_x_q <= cur_x_d;
      cur_y_q <= cur_y_d;
      light_q <= light_d;
      fwd_q   <= fwd_d;
      right_q <= right_d;
      orig_q  <= orig_d;
      sdf_q   <= sdf_d;
      done_q  <= done_d;
`ifdef SCHED_STALL_CNT_EN
      stall_q <= stall_d;
`endif
    end
  end

  always_ff @(posedge clk) begin
    w_q   <= w_d;
    h_q   <= h_d;
    xs_q  <= xs_d;
    xst_q <= xst_d;
    yst_q <= yst_d;
  end

  assign pix_valid      = issue;
  assign busy           = (state_q != ST_IDLE);
  assign frame_done     = done_q;
  assign credits        = cred_q;
  assign screen_x       = cur_x_q;
  assign screen_y       = cur_y_q;
  assign light_pos      = light_q;
  assign camera_forward = fwd_q;
  assign camera_right   = right_q;
  assign ray_origin     = orig_q;
  assign sdf_sel        = sdf_q;
`ifdef SCHED_STALL_CNT_EN
  assign stall_cycles   = stall_q;
`endif

endmodule
